// File: rtl/stall_flush_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// STALL_PERF_CNT_EN (optional macro) enables the stall-cycle performance counter.
package stall_flush_ctrl_pkg;

  localparam int unsigned STALL_W         = 6;
  localparam int unsigned PC_W            = 32;
  localparam int unsigned RUN_CNT_W       = 8;
  localparam int unsigned STALL_LIMIT_DEF = 64;
`ifdef STALL_PERF_CNT_EN
  localparam int unsigned PERF_CNT_W      = 32;
`endif

  // Hold vectors: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_REFILL = 2'd2
  } state_e;

endpackage

// File: rtl/stall_prio_enc.sv
// Stall priority encoder: the latest requesting pipeline stage selects the hold vector.
module stall_prio_enc
  import stall_flush_ctrl_pkg::*;
(
  input  logic               stallreq_if,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  output logic [STALL_W-1:0] stall_vec
);

  always_comb begin
    stall_vec = STALL_NONE;
    if (stallreq_mem)      stall_vec = STALL_MEM;
    else if (stallreq_ex)  stall_vec = STALL_EX;
    else if (stallreq_id)  stall_vec = STALL_ID;
    else if (stallreq_if)  stall_vec = STALL_IF;
  end

endmodule

// File: rtl/stall_flush_ctrl.sv
// Pipeline stall/flush controller: RUN/FLUSH/REFILL sequencer, stall-run timeout flag.
// Optional STALL_PERF_CNT_EN adds the stall_cycles performance counter port.
module stall_flush_ctrl
  import stall_flush_ctrl_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = STALL_LIMIT_DEF
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               stallreq_if,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  input  logic               flush_req,
  input  logic [PC_W-1:0]    flush_pc,
  output logic [STALL_W-1:0] stall,
  output logic               ex_bubble,
  output logic               flush,
  output logic [PC_W-1:0]    new_pc,
  output logic               stall_timeout
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cycles
`endif
);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [STALL_W-1:0]     w_req_vec;
  logic [PC_W-1:0]        r_new_pc;
  logic [RUN_CNT_W-1:0]   r_run_cnt;
  logic [RUN_CNT_W-1:0]   w_run_cnt_nxt;
  logic                   r_timeout;
  logic                   w_capture;
  logic                   w_stalling;

  stall_prio_enc u_prio_enc (
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .stall_vec    (w_req_vec)
  );

  // State register
  always_ff @(posedge Clk) begin
    if (!Rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; flush_req is only honoured in RUN and REFILL
  always_comb begin
    w_state_nxt = ST_RUN;
    case (r_state)
      ST_RUN:    w_state_nxt = flush_req ? ST_FLUSH : ST_RUN;
      ST_FLUSH:  w_state_nxt = ST_REFILL;
      ST_REFILL: w_state_nxt = flush_req ? ST_FLUSH : ST_RUN;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  // Outputs; a pending flush in RUN overrides every stall request
  always_comb begin
    stall = STALL_NONE;
    flush = 1'b0;
    if (Rst_n) begin
      case (r_state)
        ST_RUN:   if (!flush_req) stall = w_req_vec;
        ST_FLUSH: flush = 1'b1;
        default:  ;
      endcase
    end
  end

  assign ex_bubble = stall[2] & ~stall[3];

  assign w_capture  = flush_req && ((r_state == ST_RUN) || (r_state == ST_REFILL));
  assign w_stalling = (stall != STALL_NONE);

  always_comb begin
    w_run_cnt_nxt = '0;
    if (w_stalling) begin
      if (r_run_cnt == {RUN_CNT_W{1'b1}}) w_run_cnt_nxt = r_run_cnt;
      else                                w_run_cnt_nxt = r_run_cnt + RUN_CNT_W'(1);
    end
  end

  // Restart address capture, stall-run counter and sticky timeout flag
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_new_pc  <= '0;
      r_run_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_capture) r_new_pc <= flush_pc;
      r_run_cnt <= w_run_cnt_nxt;
      if (w_run_cnt_nxt == RUN_CNT_W'(STALL_LIMIT)) r_timeout <= 1'b1;
    end
  end

  assign new_pc        = r_new_pc;
  assign stall_timeout = r_timeout;

`ifdef STALL_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] r_stall_cycles;

  // Free-running count of stalled cycles, wraps naturally
  always_ff @(posedge Clk) begin
    if (!Rst_n)          r_stall_cycles <= '0;
    else if (w_stalling) r_stall_cycles <= r_stall_cycles + PERF_CNT_W'(1);
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// Directed scoreboard bench for stall_flush_ctrl (STALL_LIMIT = 4).
module tb_stall_flush_ctrl;

  logic        Clk;
  logic        Rst_n;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        ex_bubble;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  typedef struct {
    string       tag;
    logic [5:0]  stall;
    logic        bub;
    logic        flush;
    logic [31:0] pc;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  stall_flush_ctrl #(.STALL_LIMIT(4)) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .stallreq_if   (stallreq_if),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .flush_req     (flush_req),
    .flush_pc      (flush_pc),
    .stall         (stall),
    .ex_bubble     (ex_bubble),
    .flush         (flush),
    .new_pc        (new_pc),
    .stall_timeout (stall_timeout)
`ifdef STALL_PERF_CNT_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One cycle: drive after posedge, push expectation, compare at negedge
  task automatic cyc(input string tag, input logic rst, input logic [3:0] req,
                     input logic fr, input logic [31:0] fpc,
                     input logic [5:0] e_stall, input logic e_bub, input logic e_fl,
                     input logic [31:0] e_pc, input logic e_to);
    exp_t e;
    exp_t g;
    Rst_n        = rst;
    stallreq_mem = req[3];
    stallreq_ex  = req[2];
    stallreq_id  = req[1];
    stallreq_if  = req[0];
    flush_req    = fr;
    flush_pc     = fpc;
    e.tag = tag; e.stall = e_stall; e.bub = e_bub; e.flush = e_fl; e.pc = e_pc; e.to = e_to;
    exp_q.push_back(e);
    @(negedge Clk);
    g = exp_q.pop_front();
    checks++;
    assert (stall === g.stall) else begin
      failures++;
      $error("FAIL %s.stall observed=%b expected=%b", g.tag, stall, g.stall);
    end
    checks++;
    assert (ex_bubble === g.bub) else begin
      failures++;
      $error("FAIL %s.ex_bubble observed=%b expected=%b", g.tag, ex_bubble, g.bub);
    end
    checks++;
    assert (flush === g.flush) else begin
      failures++;
      $error("FAIL %s.flush observed=%b expected=%b", g.tag, flush, g.flush);
    end
    checks++;
    assert (new_pc === g.pc) else begin
      failures++;
      $error("FAIL %s.new_pc observed=%h expected=%h", g.tag, new_pc, g.pc);
    end
    checks++;
    assert (stall_timeout === g.to) else begin
      failures++;
      $error("FAIL %s.stall_timeout observed=%b expected=%b", g.tag, stall_timeout, g.to);
    end
    @(posedge Clk);
    #1;
  endtask

  // req bit order: {mem, ex, id, if}
  initial begin
    Rst_n = 1'b0; stallreq_if = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b0;
    stallreq_mem = 1'b0; flush_req = 1'b0; flush_pc = 32'h0;
    @(posedge Clk);
    #1;
    cyc("reset_hold",  1'b0, 4'b1111, 1'b1, 32'hDEAD_BEEF, 6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc("idle",        1'b1, 4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc("id_only",     1'b1, 4'b0010, 1'b0, 32'h0,   6'b000111, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc("if_id_ex",    1'b1, 4'b0111, 1'b0, 32'h0,   6'b001111, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc("mem_only",    1'b1, 4'b1000, 1'b0, 32'h0,   6'b011111, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc("idle2",       1'b1, 4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc("if_only",     1'b1, 4'b0001, 1'b0, 32'h0,   6'b000011, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc("mem_ex_if",   1'b1, 4'b1101, 1'b0, 32'h0,   6'b011111, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc("flush_req",   1'b1, 4'b1000, 1'b1, 32'h20,  6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc("flush_st",    1'b1, 4'b1000, 1'b1, 32'h40,  6'b000000, 1'b0, 1'b1, 32'h20, 1'b0);
    cyc("refill_st",   1'b1, 4'b0010, 1'b0, 32'h0,   6'b000000, 1'b0, 1'b0, 32'h20, 1'b0);
    cyc("run_after",   1'b1, 4'b0010, 1'b0, 32'h0,   6'b000111, 1'b1, 1'b0, 32'h20, 1'b0);
    cyc("flush_req2",  1'b1, 4'b0000, 1'b1, 32'h100, 6'b000000, 1'b0, 1'b0, 32'h20, 1'b0);
    cyc("flush_st2",   1'b1, 4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 1'b1, 32'h100, 1'b0);
    cyc("refill_fr",   1'b1, 4'b0100, 1'b1, 32'h200, 6'b000000, 1'b0, 1'b0, 32'h100, 1'b0);
    cyc("flush_st3",   1'b1, 4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 1'b1, 32'h200, 1'b0);
    cyc("refill3",     1'b1, 4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 1'b0, 32'h200, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc("ex_run",    1'b1, 4'b0100, 1'b0, 32'h0,   6'b001111, 1'b0, 1'b0, 32'h200, 1'b0);
    cyc("timeout_set", 1'b1, 4'b0100, 1'b0, 32'h0,   6'b001111, 1'b0, 1'b0, 32'h200, 1'b1);
    cyc("timeout_stk", 1'b1, 4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 1'b0, 32'h200, 1'b1);
    cyc("timeout_stk2",1'b1, 4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 1'b0, 32'h200, 1'b1);
    cyc("flush_req4",  1'b1, 4'b0000, 1'b1, 32'h44,  6'b000000, 1'b0, 1'b0, 32'h200, 1'b1);
    cyc("rst_in_fl",   1'b0, 4'b0100, 1'b1, 32'h88,  6'b000000, 1'b0, 1'b0, 32'h44, 1'b1);
    cyc("post_rst",    1'b1, 4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc("post_rst_id", 1'b1, 4'b0010, 1'b0, 32'h0,   6'b000111, 1'b1, 1'b0, 32'h0, 1'b0);
`ifdef STALL_PERF_CNT_EN
    cyc("perf_rst",    1'b0, 4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc("perf_st_a", 1'b1, 4'b0100, 1'b0, 32'h0,   6'b001111, 1'b0, 1'b0, 32'h0, 1'b0);
      cyc("perf_st_b", 1'b1, 4'b0010, 1'b0, 32'h0,   6'b000111, 1'b1, 1'b0, 32'h0, 1'b0);
      cyc("perf_idle", 1'b1, 4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);
    end
    @(negedge Clk);
    checks++;
    assert (stall_cycles === 32'd10) else begin
      failures++;
      $error("FAIL perf_count observed=%0d expected=%0d", stall_cycles, 10);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
